// File: rtl/serial_paralelo_rx_if.sv
// serial_paralelo_rx_if: serial input and aligned byte outputs of one receive lane
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
  modport master (output data_in, input data_out, valid_out, byte_strobe, active);
  modport slave (input data_in, output data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: single-lane deserializer that aligns on a comma run and then
// delivers aligned data bytes with a valid flag.
module serial_paralelo_rx #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input logic                clk_32f,
  input logic                reset,
  serial_paralelo_rx_if.slave bus
);
  typedef enum logic [1:0] {ST_HUNT, ST_ALIGN, ST_ACTIVE} state_t;
  localparam logic [2:0] BC_LIM = 3'(BC_COUNT);
  state_t     r_state, w_next;
  logic [7:0] r_sh, r_data;
  logic [2:0] r_bit_cnt, r_bc_cnt;
  logic       r_valid, r_strobe, r_active;
  logic       w_comma, w_eval;
  assign w_comma = r_sh == COMMA;
  assign w_eval  = r_bit_cnt == 3'd0 && r_state != ST_HUNT;
  always_ff @(posedge clk_32f or negedge reset)
    if (!reset) r_state <= ST_HUNT;
    else        r_state <= w_next;
  // An unknown compare result falls through the if, so X on the line cannot move HUNT.
  always_comb begin
    w_next = r_state;
    if (r_state == ST_HUNT) begin
      if (w_comma) w_next = (BC_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
    end else if (r_state == ST_ALIGN && w_eval) begin
      if (!w_comma) w_next = ST_HUNT;
      else if (r_bc_cnt + 3'd1 == BC_LIM) w_next = ST_ACTIVE;
    end
  end
  always_ff @(posedge clk_32f or negedge reset)
    if (!reset) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_bc_cnt  <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_sh      <= {r_sh[6:0], bus.data_in};
      r_bit_cnt <= (w_next == ST_HUNT) ? 3'd0 : r_bit_cnt + 3'd1;
      r_bc_cnt  <= (w_next == ST_HUNT) ? 3'd0 :
                   (r_state == ST_HUNT) ? 3'd1 :
                   (w_eval && w_comma && r_bc_cnt != BC_LIM) ? r_bc_cnt + 3'd1 : r_bc_cnt;
      r_strobe  <= w_eval;
      r_active  <= r_active | (w_next == ST_ACTIVE);
      if (r_state == ST_ACTIVE && w_eval) begin
        r_valid <= !w_comma;
        if (!w_comma) r_data <= r_sh;
      end
    end
  assign bus.data_out    = r_data;
  assign bus.valid_out   = r_valid;
  assign bus.byte_strobe = r_strobe;
  assign bus.active      = r_active;
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: directed bench for serial_paralelo_rx covering lock, data,
// idle commas, broken comma runs, offset alignment and asynchronous reset.
module tb_serial_paralelo_rx;
  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  serial_paralelo_rx_if bus ();
  serial_paralelo_rx dut (.clk_32f(clk_32f), .reset(reset), .bus(bus));
  always #5 clk_32f = ~clk_32f;
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] c_data [8];
  logic       c_valid [8], c_strobe [8], c_active [8];
  logic       acc_valid, acc_active;
  int         n_strobe;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Each capture is taken at the negedge before that bit is driven, so index j
  // reflects the DUT after the edge that sampled the previous serial bit.
  task automatic send_byte(input logic [7:0] b);
    n_strobe = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_32f);
      c_data[j]   = bus.data_out;
      c_valid[j]  = bus.valid_out;
      c_strobe[j] = bus.byte_strobe;
      c_active[j] = bus.active;
      acc_valid   = acc_valid | bus.valid_out;
      acc_active  = acc_active | bus.active;
      n_strobe    = n_strobe + int'(bus.byte_strobe);
      bus.data_in = b[7-j];
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    bus.data_in = b;
  endtask
  task automatic restart();
    @(negedge clk_32f);
    reset = 1'b0;
    bus.data_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    acc_valid = 1'b0;
    acc_active = 1'b0;
  endtask
  initial begin
    bus.data_in = 1'b0;
    acc_valid = 1'b0;
    acc_active = 1'b0;
    for (int i = 0; i < 95; i++) begin
      @(negedge clk_32f);
      bus.data_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk_32f);
    check("rst_data", bus.data_out, 8'h00);
    check("rst_valid", 8'(bus.valid_out), 8'h00);
    check("rst_strobe", 8'(bus.byte_strobe), 8'h00);
    check("rst_active", 8'(bus.active), 8'h00);
    bus.data_in = 1'b0;
    reset = 1'b1;
    repeat (4) send_byte(8'hBC);
    check("lock_valid_quiet", 8'(acc_valid), 8'h00);
    send_byte(8'hA5);
    check("lock_active_early", 8'(c_active[0]), 8'h00);
    check("lock_active_rise", 8'(c_active[1]), 8'h01);
    send_byte(8'h3C);
    check("a5_data", c_data[1], 8'hA5);
    check("a5_valid_first", 8'(c_valid[1]), 8'h01);
    check("a5_valid_last", 8'(c_valid[7]), 8'h01);
    check("a5_strobe_pos", 8'(c_strobe[1]), 8'h01);
    check("a5_strobe_cnt", 8'(n_strobe), 8'h01);
    send_byte(8'hBC);
    check("a5_hold_8th", c_data[0], 8'hA5);
    check("a5_valid_8th", 8'(c_valid[0]), 8'h01);
    check("3c_data", c_data[1], 8'h3C);
    check("3c_valid", 8'(c_valid[7]), 8'h01);
    check("3c_strobe_cnt", 8'(n_strobe), 8'h01);
    send_byte(8'h77);
    check("idle_valid", 8'(c_valid[1]), 8'h00);
    check("idle_data_hold", c_data[7], 8'h3C);
    check("idle_active", 8'(c_active[7]), 8'h01);
    check("idle_strobe", 8'(c_strobe[1]), 8'h01);
    send_bit(1'b0);
    send_bit(1'b0);
    check("77_data", bus.data_out, 8'h77);
    check("77_valid", 8'(bus.valid_out), 8'h01);
    #2 reset = 1'b0;
    #1;
    check("async_active", 8'(bus.active), 8'h00);
    check("async_valid", 8'(bus.valid_out), 8'h00);
    check("async_data", bus.data_out, 8'h00);
    restart();
    repeat (3) send_byte(8'hBC);
    send_byte(8'h55);
    repeat (4) send_byte(8'hBC);
    check("broken_no_active", 8'(acc_active), 8'h00);
    send_byte(8'h00);
    check("broken_active_early", 8'(c_active[0]), 8'h00);
    check("broken_active_rise", 8'(c_active[1]), 8'h01);
    check("broken_valid_quiet", 8'(acc_valid), 8'h00);
    restart();
    repeat (3) send_bit(1'b0);
    repeat (4) send_byte(8'hBC);
    send_byte(8'h0B);
    check("mis_active_early", 8'(c_active[0]), 8'h00);
    check("mis_active_rise", 8'(c_active[1]), 8'h01);
    send_byte(8'hC0);
    check("mis_0b_data", c_data[1], 8'h0B);
    check("mis_0b_valid", 8'(c_valid[7]), 8'h01);
    send_byte(8'h00);
    check("mis_c0_data", c_data[1], 8'hC0);
    check("mis_c0_valid", 8'(c_valid[7]), 8'h01);
    check("mis_c0_strobes", 8'(n_strobe), 8'h01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
